// File: rtl/proc_param.sv
// proc_param: multi-cycle processor running the 16-bit mv/branch/alu/ld/st ISA on a
// DW-bit datapath, with a MemReady handshake that stalls fetch, load and store.
module proc_param #(
    parameter int              DW      = 16,
    parameter int              AW      = 16,
    parameter logic [DW-1:0]   SP_INIT = '0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    input  logic          MemReady,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DOUT,
    output logic          W,
    output logic          MemRd,
    output logic          Done
);
    localparam logic [2:0] OP_MV  = 3'd0, OP_MVT = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                           OP_LD  = 3'd4, OP_ST  = 3'd5, OP_AND = 3'd6, OP_CMP = 3'd7;
    localparam logic [DW-1:0] ONE = DW'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB} state_t;
    state_t state;

    logic [7:0][DW-1:0] rf;
    logic [15:0]        ir;
    logic [DW-1:0]      g;
    logic               z_flag, n_flag, c_flag;

    logic [2:0]    op, rx, ry;
    logic          m;
    logic [DW-1:0] imm, mvt_val, a_op, b_op, sp_dec, mem_ptr, alu_res;
    logic [DW:0]   sum;
    logic          is_sub, alu_c, taken;

    assign op = ir[15:13];
    assign m  = ir[12];
    assign rx = ir[11:9];
    assign ry = ir[2:0];

    assign imm     = {{(DW-9){ir[8]}}, ir[8:0]};
    assign mvt_val = {ir[7:0], {(DW-8){1'b0}}};
    assign a_op    = rf[rx];
    assign b_op    = m ? imm : rf[ry];
    assign sp_dec  = rf[5] - ONE;

    // Subtraction as A + ~B + 1 so the carry out doubles as "no borrow".
    assign is_sub  = (op == OP_SUB) || (op == OP_CMP);
    assign sum     = {1'b0, a_op} + {1'b0, (is_sub ? ~b_op : b_op)} + {{DW{1'b0}}, is_sub};
    assign alu_res = (op == OP_AND) ? (a_op & b_op) : sum[DW-1:0];
    assign alu_c   = (op == OP_AND) ? 1'b0 : sum[DW];

    always_comb begin
        mem_ptr = rf[ry];
        if (m) mem_ptr = (op == OP_ST) ? sp_dec : rf[5];
    end

    always_comb begin
        taken = 1'b1;
        case (rx)
            3'd1: taken = z_flag;
            3'd2: taken = !z_flag;
            3'd3: taken = !c_flag;
            3'd4: taken = c_flag;
            3'd5: taken = !n_flag;
            3'd6: taken = n_flag;
            default: taken = 1'b1;
        endcase
    end

    assign Done = (state == S_EXEC && (op == OP_MV || op == OP_MVT || op == OP_CMP))
                || (state == S_WB)
                || (state == S_MEM && MemReady);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            rf     <= '0;
            rf[5]  <= SP_INIT;
            ir     <= '0;
            g      <= '0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            c_flag <= 1'b0;
            ADDR   <= '0;
            DOUT   <= '0;
            W      <= 1'b0;
            MemRd  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Run) begin
                    ADDR  <= rf[7][AW-1:0];
                    MemRd <= 1'b1;
                    state <= S_FETCH;
                end
                S_FETCH: if (MemReady) begin
                    ir    <= DIN[15:0];
                    rf[7] <= rf[7] + ONE;
                    MemRd <= 1'b0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    case (op)
                        OP_MV:  rf[rx] <= b_op;
                        OP_MVT: begin
                            if (m) rf[rx] <= mvt_val;
                            else if (taken) begin
                                if (rx == 3'd7) rf[6] <= rf[7];
                                rf[7] <= rf[7] + imm;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            g      <= alu_res;
                            z_flag <= (alu_res == '0);
                            n_flag <= alu_res[DW-1];
                            c_flag <= alu_c;
                            state  <= S_WB;
                        end
                        OP_CMP: begin
                            z_flag <= (alu_res == '0);
                            n_flag <= alu_res[DW-1];
                            c_flag <= alu_c;
                        end
                        OP_LD: begin
                            ADDR  <= mem_ptr[AW-1:0];
                            MemRd <= 1'b1;
                            state <= S_MEM;
                        end
                        default: begin
                            ADDR  <= mem_ptr[AW-1:0];
                            DOUT  <= a_op;
                            W     <= 1'b1;
                            if (m) rf[5] <= sp_dec;
                            state <= S_MEM;
                        end
                    endcase
                end
                S_MEM: if (MemReady) begin
                    W     <= 1'b0;
                    MemRd <= 1'b0;
                    state <= S_IDLE;
                    // pop increments sp first so a pop into r5 keeps the loaded value
                    if (op == OP_LD) begin
                        if (m) rf[5] <= rf[5] + ONE;
                        rf[rx] <= DIN;
                    end
                end
                S_WB: begin
                    rf[rx] <= g;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: a 16-bit core with SP_INIT=0x1000 runs a short
// program, a 32-bit core checks mvt/cmp; results are compared to hand-worked values.
module tb_proc_param;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        run16 = 1'b0, rdy16 = 1'b1, run32 = 1'b0;
    logic [15:0] addr16, dout16, din16;
    logic        w16, rd16, done16;
    logic [15:0] addr32;
    logic [31:0] dout32, din32;
    logic        w32, rd32, done32;
    logic [15:0] mem16 [0:4095];
    logic [15:0] mem32 [0:15];
    int          nerr = 0, nchk = 0, wr_cnt = 0, n = 0;
    logic [15:0] wr_addr = '0, wr_data = '0;
    logic        moved = 1'b0, found = 1'b0;

    always #5 Clock = ~Clock;

    assign din16 = mem16[addr16[11:0]];
    assign din32 = {16'h0, mem32[addr32[3:0]]};

    proc_param #(.DW(16), .AW(16), .SP_INIT(16'h1000)) dut16 (
        .Clock(Clock), .Resetn(Resetn), .Run(run16), .DIN(din16), .MemReady(rdy16),
        .ADDR(addr16), .DOUT(dout16), .W(w16), .MemRd(rd16), .Done(done16));

    proc_param #(.DW(32), .AW(16), .SP_INIT(32'h0)) dut32 (
        .Clock(Clock), .Resetn(Resetn), .Run(run32), .DIN(din32), .MemReady(1'b1),
        .ADDR(addr32), .DOUT(dout32), .W(w32), .MemRd(rd32), .Done(done32));

    function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                        input logic [2:0] rx, input logic [8:0] d);
        return {op, m, rx, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One 16-bit instruction; fs/ms = MemReady-low cycles in fetch/mem. Returns at
    // posedge+1 after retire so architectural state can be inspected.
    task automatic run16_instr(input int fs, input int ms, output int cyc);
        int          nreq = 0;
        logic        prev = 1'b0, req;
        logic [15:0] pa = '0, pd = '0;
        cyc = 0;
        moved = 1'b0;
        while (cyc < 40) begin
            @(negedge Clock);
            cyc++;
            req = rd16 | w16;
            if (req && !prev) nreq++;
            if (req && nreq == 1 && fs > 0) begin rdy16 = 1'b0; fs--; end
            else if (req && nreq == 2 && ms > 0) begin rdy16 = 1'b0; ms--; end
            else rdy16 = 1'b1;
            if (req && prev && (addr16 !== pa || dout16 !== pd)) moved = 1'b1;
            prev = req; pa = addr16; pd = dout16;
            #1;
            if (w16 && rdy16) begin
                wr_cnt++;
                wr_addr = addr16;
                wr_data = dout16;
                mem16[addr16[11:0]] = dout16;
            end
            if (done16) break;
        end
        chk("done16_seen", done16, 1);
        @(posedge Clock);
        #1;
    endtask

    task automatic run32_instr(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge Clock);
            #1;
            cyc++;
            if (done32) break;
        end
        chk("done32_seen", done32, 1);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem16[i] = '0;
        for (int i = 0; i < 16; i++) mem32[i] = '0;
        mem16[16'h00] = enc(3'd0, 1'b1, 3'd0, 9'h1FF); // mv r0,#-1
        mem16[16'h01] = enc(3'd2, 1'b1, 3'd0, 9'h001); // add r0,#1
        mem16[16'h02] = enc(3'd1, 1'b1, 3'd2, 9'h0BE); // mvt r2,#0xBE
        mem16[16'h03] = enc(3'd2, 1'b1, 3'd2, 9'h0EF); // add r2,#0xEF
        mem16[16'h04] = enc(3'd5, 1'b1, 3'd2, 9'h005); // push r2
        mem16[16'h05] = enc(3'd4, 1'b1, 3'd3, 9'h005); // pop r3
        mem16[16'h06] = enc(3'd4, 1'b0, 3'd4, 9'h001); // ld r4,[r1]
        mem16[16'h07] = enc(3'd0, 1'b1, 3'd7, 9'h020); // mv pc,#0x20
        mem16[16'h20] = enc(3'd1, 1'b0, 3'd7, 9'h005); // bl #5
        mem16[16'h26] = enc(3'd7, 1'b1, 3'd0, 9'h000); // cmp r0,#0
        mem16[16'h27] = enc(3'd1, 1'b0, 3'd2, 9'h003); // bne #3
        mem16[16'h28] = enc(3'd1, 1'b0, 3'd1, 9'h002); // beq #2
        mem16[16'h2B] = enc(3'd3, 1'b1, 3'd0, 9'h001); // sub r0,#1
        mem16[16'h2C] = enc(3'd6, 1'b1, 3'd3, 9'h0F0); // and r3,#0xF0
        mem16[16'h2D] = enc(3'd5, 1'b0, 3'd3, 9'h001); // st r3,[r1]
        mem16[16'h2E] = enc(3'd5, 1'b0, 3'd2, 9'h001); // st r2,[r1]
        mem32[0]      = enc(3'd1, 1'b1, 3'd1, 9'h080); // mvt r1,#0x80
        mem32[1]      = enc(3'd7, 1'b1, 3'd1, 9'h001); // cmp r1,#1

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_addr", addr16, 16'h0);
        chk("rst_dout", dout16, 16'h0);
        chk("rst_w", w16, 0);
        chk("rst_memrd", rd16, 0);
        chk("rst_done", done16, 0);
        chk("rst_sp", dut16.rf[5], 16'h1000);
        chk("rst_w32", w32, 0);

        Resetn = 1'b1;
        run32 = 1'b1;
        run32_instr(n);
        chk("mvt32_lat", n, 3);
        chk("mvt32_r1", dut32.rf[1], 32'h8000_0000);
        run32_instr(n);
        run32 = 1'b0;
        chk("cmp32_lat", n, 3);
        chk("cmp32_r1", dut32.rf[1], 32'h8000_0000);
        chk("cmp32_n", dut32.n_flag, 0);
        chk("cmp32_c", dut32.c_flag, 1);
        chk("cmp32_z", dut32.z_flag, 0);

        run16 = 1'b1;
        run16_instr(0, 0, n);
        chk("mv_lat", n, 3);
        chk("mv_r0", dut16.rf[0], 16'hFFFF);
        run16_instr(0, 0, n);
        chk("add_lat", n, 4);
        chk("add_r0", dut16.rf[0], 16'h0000);
        chk("add_z", dut16.z_flag, 1);
        chk("add_c", dut16.c_flag, 1);
        chk("add_n", dut16.n_flag, 0);
        run16_instr(0, 0, n);
        chk("mvt_r2", dut16.rf[2], 16'hBE00);
        run16_instr(0, 0, n);
        chk("add_r2", dut16.rf[2], 16'hBEEF);
        run16_instr(0, 0, n);
        chk("push_lat", n, 4);
        chk("push_addr", wr_addr, 16'h0FFF);
        chk("push_data", wr_data, 16'hBEEF);
        chk("push_sp", dut16.rf[5], 16'h0FFF);
        run16_instr(0, 0, n);
        chk("pop_lat", n, 4);
        chk("pop_r3", dut16.rf[3], 16'hBEEF);
        chk("pop_sp", dut16.rf[5], 16'h1000);
        run16_instr(3, 2, n);
        chk("ld_stall_lat", n, 9);
        chk("ld_r4", dut16.rf[4], 16'h11FF);
        chk("ld_addr_stable", moved, 0);
        run16_instr(0, 0, n);
        chk("mvpc_lat", n, 3);
        chk("mvpc_pc", dut16.rf[7], 16'h0020);
        run16_instr(0, 0, n);
        chk("bl_lat", n, 3);
        chk("bl_lr", dut16.rf[6], 16'h0021);
        chk("bl_pc", dut16.rf[7], 16'h0026);
        run16_instr(0, 0, n);
        chk("cmp_lat", n, 3);
        chk("cmp_r0", dut16.rf[0], 16'h0000);
        chk("cmp_z", dut16.z_flag, 1);
        run16_instr(0, 0, n);
        chk("bne_lat", n, 3);
        chk("bne_pc", dut16.rf[7], 16'h0028);
        run16_instr(0, 0, n);
        chk("beq_pc", dut16.rf[7], 16'h002B);
        run16_instr(0, 0, n);
        chk("sub_lat", n, 4);
        chk("sub_r0", dut16.rf[0], 16'hFFFF);
        chk("sub_n", dut16.n_flag, 1);
        chk("sub_c", dut16.c_flag, 0);
        chk("sub_z", dut16.z_flag, 0);
        run16_instr(0, 0, n);
        chk("and_r3", dut16.rf[3], 16'h00E0);
        chk("and_c", dut16.c_flag, 0);
        chk("and_z", dut16.z_flag, 0);
        run16_instr(0, 0, n);
        chk("st_lat", n, 4);
        chk("st_addr", wr_addr, 16'h0000);
        chk("st_data", wr_data, 16'h00E0);

        // Next store is held in MEM, then reset lands mid-request.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clock);
            rdy16 = w16 ? 1'b0 : 1'b1;
            #1;
            if (w16) found = 1'b1;
        end
        chk("st2_pending", w16, 1);
        Resetn = 1'b0;
        #1;
        chk("rst_async_w", w16, 0);
        chk("rst_async_rd", rd16, 0);
        rdy16 = 1'b1;
        run16 = 1'b0;
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (w16 && rdy16) wr_cnt++;
        end
        chk("rst_no_write", wr_cnt, 2);
        chk("rst2_addr", addr16, 16'h0);
        chk("rst2_dout", dout16, 16'h0);
        chk("rst2_pc", dut16.rf[7], 16'h0);
        chk("rst2_sp", dut16.rf[5], 16'h1000);
        chk("idle_memrd", rd16, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
